frame_aligner: RTL and testbench
================================

FRAME_ALIGNER -- requirements
Module: frame_aligner

Interface
REQ-001 Parameter: frame_length, 810, bytes per frame incl. 6 framing bytes (min 8).
REQ-002 Parameter: sync_confirm, 2, consecutive on-position pattern hits needed to enter SYNC.
REQ-003 Parameter: loss_count, 4, consecutive on-position misses that drop SYNC.
REQ-004 Port: rxclk  in  1  byte clock, the block's only clock.
REQ-005 Port: rst  in  1  asynchronous, active-low reset (asserted at 0).
REQ-006 Port: rxd  in  8  byte-aligned line data, one byte per rxclk.
REQ-007 Port: rxd_out  out  8  rxd delayed one cycle (descrambled when enabled).
REQ-008 Port: frame_begin  out  1  one-cycle pulse coincident with first payload byte on rxd_out; feeds frame_receiver.frame_begin.
REQ-009 Port: in_sync  out  1  high while in SYNC.
REQ-010 Port: lof  out  1  one-cycle pulse on SYNC->HUNT transition.

Function
REQ-011 Framing pattern: F6 F6 F6 28 28 28, first byte earliest.
REQ-012 A 6-byte window shall hold the last six received bytes; "match" = window equals pattern, evaluated each cycle on registered bytes.
REQ-013 byte_cnt (width clog2(frame_length)) shall reset to 0 in the cycle after an accepted match, then increment per byte, wrapping frame_length-1 -> 0.
REQ-014 Expected position = cycle in which byte_cnt wraps to 0.
REQ-015 States: HUNT, PRESYNC, SYNC.
REQ-016 HUNT: any match -> PRESYNC, confirm count = 1, byte_cnt realigned.
REQ-017 PRESYNC: match at expected position increments confirm count; miss at expected position -> HUNT; matches elsewhere ignored.
REQ-018 PRESYNC: confirm count reaching sync_confirm -> SYNC; frame_begin asserted for that frame.
REQ-019 SYNC: match at expected position clears miss count and asserts frame_begin; off-position matches ignored, no realignment.
REQ-020 SYNC: miss at expected position increments miss count, no frame_begin; miss count reaching loss_count -> HUNT with lof pulse; in_sync low same cycle.
REQ-021 Latency: rxd -> rxd_out exactly 1 cycle; frame_begin aligned to the byte after the final 0x28 on rxd_out.
REQ-022 frame_begin never asserted in HUNT or for off-position matches.
REQ-023 sync_confirm = 1: first HUNT match goes directly to SYNC with frame_begin.

Reset
REQ-024 On rst low: state HUNT, counters 0, window 0, rxd_out 0, frame_begin 0, in_sync 0, lof 0.
REQ-025 Reset mid-frame aborts immediately; after release first frame_begin only after full reacquisition.

Configuration
REQ-026 Macro FRAME_ALIGNER_DESCRAMBLE_EN: when defined, payload bytes on rxd_out XORed with frame-synchronous x^7+x^6+1 sequence, seed 7F reloaded on frame_begin, MSB first; framing bytes unaltered.
REQ-027 Without macro: rxd_out is plain 1-cycle delayed rxd; no scrambler logic.

Structure
REQ-028 Package frame_pkg: A1 (F6), A2 (28), pattern length 6, state enum.
REQ-029 One sub-module, sonet_descrambler (LFSR + XOR, load/enable), instantiated only under the macro.

Verification (frame_length=16, sync_confirm=2, loss_count=2)
REQ-030 Two frames with pattern at 16-byte spacing, payload 00 01 ab cd... -> frame_begin on second frame with rxd_out=00 that cycle, in_sync=1.
REQ-031 In SYNC, pattern copy inside payload -> no frame_begin, byte_cnt unchanged.
REQ-032 In SYNC, corrupt pattern (F6->F7) twice consecutively -> no frame_begin either frame, lof pulse, in_sync=0; single corruption -> stays SYNC.
REQ-033 PRESYNC, second pattern missing at expected position -> back to HUNT, no frame_begin.
REQ-034 rst low mid-payload in SYNC -> all outputs 0 next edge, reacquire after 2 frames.
REQ-035 With FRAME_ALIGNER_DESCRAMBLE_EN, zero payload -> rxd_out payload FE 04 18 ... sequence, framing bytes F6/28 passed unchanged.

Source files
------------

// File: rtl/frame_pkg.sv
// -----------------------------------------------------------------------------
// frame_pkg
// Shared definitions for the SONET-style frame aligner:
//   A1 / A2          framing byte values (F6 / 28)
//   PATTERN_LEN      number of framing bytes at the head of each frame
//   FRAME_PATTERN    A1 A1 A1 A2 A2 A2, earliest byte in the most significant lane
//   align_state_t    HUNT / PRESYNC / SYNC
//   DESCRAMBLE_SEED  frame-synchronous descrambler seed
//   lfsr_key / lfsr_advance   byte-wide helpers for the x^7+x^6+1 sequence
// -----------------------------------------------------------------------------
package frame_pkg;

    localparam logic [7:0] A1          = 8'hF6;
    localparam logic [7:0] A2          = 8'h28;
    localparam int         PATTERN_LEN = 6;

    localparam logic [8*PATTERN_LEN-1:0] FRAME_PATTERN = {A1, A1, A1, A2, A2, A2};

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PRESYNC = 2'd1,
        SYNC    = 2'd2
    } align_state_t;

    localparam logic [6:0] DESCRAMBLE_SEED = 7'h7F;

    // Eight keystream bits for one byte, first generated bit in the MSB.
    function automatic logic [7:0] lfsr_key(input logic [6:0] state);
        logic [6:0] s;
        logic [7:0] key;
        s   = state;
        key = '0;
        for (int i = 0; i < 8; i++) begin
            key = {key[6:0], s[6]};
            s   = {s[5:0], s[6] ^ s[5]};
        end
        return key;
    endfunction

    // LFSR state after producing one byte of keystream.
    function automatic logic [6:0] lfsr_advance(input logic [6:0] state);
        logic [6:0] s;
        s = state;
        for (int i = 0; i < 8; i++) begin
            s = {s[5:0], s[6] ^ s[5]};
        end
        return s;
    endfunction

endpackage

// File: rtl/sonet_descrambler.sv
// -----------------------------------------------------------------------------
// sonet_descrambler
// Frame-synchronous x^7+x^6+1 descrambler, one byte per clock.
//   rxclk   byte clock
//   rst     asynchronous active-low reset
//   load    restart the sequence from the seed for the current byte
//   enable  XOR the current byte and advance the sequence
//   din     byte to descramble
//   dout    din XOR keystream when enabled, din otherwise (combinational)
// -----------------------------------------------------------------------------
module sonet_descrambler
    import frame_pkg::*;
(
    input  logic       rxclk,
    input  logic       rst,
    input  logic       load,
    input  logic       enable,
    input  logic [7:0] din,
    output logic [7:0] dout
);

    logic [6:0] lfsr;
    logic [6:0] lfsr_cur;

    // A load applies to the byte presented in the same cycle, so the seed
    // bypasses the register rather than waiting a cycle.
    assign lfsr_cur = load ? DESCRAMBLE_SEED : lfsr;
    assign dout     = enable ? (din ^ lfsr_key(lfsr_cur)) : din;

    always_ff @(posedge rxclk or negedge rst) begin
        if (!rst) begin
            lfsr <= DESCRAMBLE_SEED;
        end else if (enable) begin
            lfsr <= lfsr_advance(lfsr_cur);
        end
    end

endmodule

// File: rtl/frame_aligner.sv
// -----------------------------------------------------------------------------
// frame_aligner
// Finds the A1A1A1A2A2A2 framing pattern in a byte-aligned stream, confirms it
// at frame_length spacing (HUNT -> PRESYNC -> SYNC) and flags the first payload
// byte of every in-sync frame.
//   rxclk        byte clock
//   rst          asynchronous active-low reset
//   rxd          incoming byte
//   rxd_out      rxd delayed one cycle (payload descrambled when enabled)
//   frame_begin  pulse with the first payload byte on rxd_out
//   in_sync      high while in SYNC
//   lof          pulse on SYNC -> HUNT
// Build option: FRAME_ALIGNER_DESCRAMBLE_EN adds the payload descrambler.
// -----------------------------------------------------------------------------
module frame_aligner
    import frame_pkg::*;
#(
    parameter int frame_length = 810,
    parameter int sync_confirm = 2,
    parameter int loss_count   = 4
) (
    input  logic       rxclk,
    input  logic       rst,
    input  logic [7:0] rxd,
    output logic [7:0] rxd_out,
    output logic       frame_begin,
    output logic       in_sync,
    output logic       lof
);

    localparam int CNT_W  = $clog2(frame_length);
    localparam int CONF_W = $clog2(sync_confirm + 1);
    localparam int MISS_W = $clog2(loss_count + 1);
    localparam int WIN_W  = 8 * PATTERN_LEN;

    localparam logic [CNT_W-1:0]  LAST_CNT    = CNT_W'(frame_length - 1);
    localparam logic [CONF_W-1:0] CONF_TARGET = CONF_W'(sync_confirm);
    localparam logic [MISS_W-1:0] MISS_TARGET = MISS_W'(loss_count);

    align_state_t      state, state_next;
    logic [WIN_W-1:0]  window;
    logic [CNT_W-1:0]  byte_cnt, byte_cnt_next;
    logic [CONF_W-1:0] conf_cnt, conf_next;
    logic [MISS_W-1:0] miss_cnt, miss_next;
    logic              fb_next;
    logic              lof_next;
    logic              match;
    logic              at_expected;

    // The newest byte sits in the low lane, so the oldest framing byte
    // lines up with the most significant lane of FRAME_PATTERN.
    assign match       = (window == FRAME_PATTERN);
    // The pattern is due in the cycle where byte_cnt is about to wrap to 0.
    assign at_expected = (byte_cnt == LAST_CNT);

    // State register plus the counters and registered pulses it drives.
    always_ff @(posedge rxclk or negedge rst) begin
        if (!rst) begin
            state       <= HUNT;
            // NOTE: the byte window is reset too, otherwise stale bytes from
            // before reset could complete a false pattern right after release.
            window      <= '0;
            byte_cnt    <= '0;
            conf_cnt    <= '0;
            miss_cnt    <= '0;
            frame_begin <= 1'b0;
            lof         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples
            // the pre-edge values, independent of statement order.
            state       <= state_next;
            window      <= {window[WIN_W-9:0], rxd};
            byte_cnt    <= byte_cnt_next;
            conf_cnt    <= conf_next;
            miss_cnt    <= miss_next;
            frame_begin <= fb_next;
            lof         <= lof_next;
        end
    end

    // Next-state and counter decisions.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves one unassigned, which would infer a latch.
        state_next    = state;
        byte_cnt_next = at_expected ? '0 : byte_cnt + 1'b1;
        conf_next     = conf_cnt;
        miss_next     = miss_cnt;
        fb_next       = 1'b0;
        lof_next      = 1'b0;

        unique case (state)
            HUNT: begin
                if (match) begin
                    byte_cnt_next = '0;
                    conf_next     = CONF_W'(1);
                    miss_next     = '0;
                    if (sync_confirm <= 1) begin
                        state_next = SYNC;
                        fb_next    = 1'b1;
                    end else begin
                        state_next = PRESYNC;
                    end
                end
            end
            PRESYNC: begin
                if (at_expected) begin
                    if (match) begin
                        conf_next = conf_cnt + 1'b1;
                        if (conf_next == CONF_TARGET) begin
                            state_next = SYNC;
                            fb_next    = 1'b1;
                            miss_next  = '0;
                        end
                    end else begin
                        state_next = HUNT;
                        conf_next  = '0;
                    end
                end
            end
            SYNC: begin
                if (at_expected) begin
                    if (match) begin
                        miss_next = '0;
                        fb_next   = 1'b1;
                    end else begin
                        miss_next = miss_cnt + 1'b1;
                        if (miss_next == MISS_TARGET) begin
                            state_next = HUNT;
                            lof_next   = 1'b1;
                            miss_next  = '0;
                            conf_next  = '0;
                        end
                    end
                end
            end
            default: begin
                state_next = HUNT;
            end
        endcase
    end

    // Outputs decoded from the state register.
    always_comb begin
        in_sync = (state == SYNC);
    end

`ifdef FRAME_ALIGNER_DESCRAMBLE_EN
    // byte_cnt is 0 on the frame_begin byte, so payload spans 0..this value.
    localparam logic [CNT_W-1:0] LAST_PAYLOAD_CNT = CNT_W'(frame_length - PATTERN_LEN - 1);

    logic payload_run;

    // Covers the payload bytes after the frame_begin byte of an in-sync frame.
    always_ff @(posedge rxclk or negedge rst) begin
        if (!rst) begin
            payload_run <= 1'b0;
        end else begin
            payload_run <= (frame_begin || payload_run) && (byte_cnt != LAST_PAYLOAD_CNT);
        end
    end

    sonet_descrambler u_descrambler (
        .rxclk  (rxclk),
        .rst    (rst),
        .load   (frame_begin),
        .enable (frame_begin || payload_run),
        .din    (window[7:0]),
        .dout   (rxd_out)
    );
`else
    assign rxd_out = window[7:0];
`endif

endmodule

// File: tb/tb_frame_aligner.sv
// -----------------------------------------------------------------------------
// tb_frame_aligner
// Directed stimulus for frame_aligner (frame_length=16, sync_confirm=2,
// loss_count=2). A behavioural model tracks the aligner in terms of absolute
// byte positions and is compared with the DUT every cycle; literal checks pin
// the key events. Also builds with FRAME_ALIGNER_DESCRAMBLE_EN.
// -----------------------------------------------------------------------------
module tb_frame_aligner;

    localparam int L   = 16;
    localparam int SC  = 2;
    localparam int LC  = 2;
    localparam int PAY = L - 6;

`ifdef FRAME_ALIGNER_DESCRAMBLE_EN
    localparam logic [7:0] PAY0_OUT = 8'hFE;  // 00 ^ FE
    localparam logic [7:0] PAY1_OUT = 8'h05;  // 01 ^ 04
`else
    localparam logic [7:0] PAY0_OUT = 8'h00;
    localparam logic [7:0] PAY1_OUT = 8'h01;
`endif

    logic       rxclk = 1'b0;
    logic       rst   = 1'b1;
    logic [7:0] rxd   = 8'h00;
    logic [7:0] rxd_out;
    logic       frame_begin;
    logic       in_sync;
    logic       lof;

    frame_aligner #(
        .frame_length (L),
        .sync_confirm (SC),
        .loss_count   (LC)
    ) dut (
        .rxclk       (rxclk),
        .rst         (rst),
        .rxd         (rxd),
        .rxd_out     (rxd_out),
        .frame_begin (frame_begin),
        .in_sync     (in_sync),
        .lof         (lof)
    );

    always #5 rxclk = ~rxclk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------ model
    localparam int M_HUNT = 0;
    localparam int M_PRE  = 1;
    localparam int M_SYNC = 2;

    byte unsigned pattern [6] = '{8'hF6, 8'hF6, 8'hF6, 8'h28, 8'h28, 8'h28};
    byte unsigned hist [$];
    int           mode;
    int           hits;
    int           misses;
    int           exp_end;   // absolute index of the byte that must end the next pattern
    int           idx;       // absolute index of the byte being sampled
    int           pay_left;
    int           key_pos;
    logic [7:0]   e_rxd;
    logic         e_fb;
    logic         e_lof;
    logic         e_sync;

`ifdef FRAME_ALIGNER_DESCRAMBLE_EN
    byte unsigned key [PAY];
    initial begin
        bit kb [8*PAY];
        for (int n = 0; n < 8*PAY; n++) kb[n] = (n < 7) ? 1'b1 : (kb[n-7] ^ kb[n-6]);
        for (int i = 0; i < PAY; i++) begin
            key[i] = 8'h00;
            for (int b = 0; b < 8; b++) key[i] = {key[i][6:0], kb[8*i+b]};
        end
    end
`endif

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 6; i++) hist.push_back(8'h00);
        mode     = M_HUNT;
        hits     = 0;
        misses   = 0;
        exp_end  = 0;
        idx      = 0;
        pay_left = 0;
        key_pos  = 0;
        e_rxd    = 8'h00;
        e_fb     = 1'b0;
        e_lof    = 1'b0;
        e_sync   = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] b);
        bit hit;
        int last;
        hit = 1'b1;
        for (int i = 0; i < 6; i++) if (hist[i] != pattern[i]) hit = 1'b0;
        last  = idx - 1;
        e_fb  = 1'b0;
        e_lof = 1'b0;
        case (mode)
            M_HUNT: if (hit) begin
                exp_end = last + L;
                hits    = 1;
                misses  = 0;
                if (SC == 1) begin mode = M_SYNC; e_fb = 1'b1; end
                else mode = M_PRE;
            end
            M_PRE: if (last == exp_end) begin
                exp_end += L;
                if (hit) begin
                    hits++;
                    if (hits == SC) begin mode = M_SYNC; e_fb = 1'b1; misses = 0; end
                end else begin
                    mode = M_HUNT;
                end
            end
            default: if (last == exp_end) begin
                exp_end += L;
                if (hit) begin
                    misses = 0;
                    e_fb   = 1'b1;
                end else begin
                    misses++;
                    if (misses == LC) begin mode = M_HUNT; e_lof = 1'b1; end
                end
            end
        endcase
        hist.push_back(b);
        void'(hist.pop_front());
        idx++;
        e_rxd = b;
`ifdef FRAME_ALIGNER_DESCRAMBLE_EN
        if (e_fb) begin pay_left = PAY; key_pos = 0; end
        if (pay_left > 0) begin
            e_rxd = b ^ key[key_pos];
            key_pos++;
            pay_left--;
        end
`endif
        e_sync = (mode == M_SYNC);
    endtask

    always @(posedge rxclk or negedge rst) begin
        if (!rst) model_reset();
        else      model_step(rxd);
    end

    always @(negedge rxclk) begin
        if (cmp_en) begin
            check("rxd_out",     32'(rxd_out),     32'(e_rxd));
            check("frame_begin", 32'(frame_begin), 32'(e_fb));
            check("in_sync",     32'(in_sync),     32'(e_sync));
            check("lof",         32'(lof),         32'(e_lof));
        end
    end

    // --------------------------------------------------------------- stimulus
    function automatic logic [7:0] pay_byte(input int i, input bit copy);
        logic [7:0] v;
        case (i)
            0:       v = 8'h00;
            1:       v = 8'h01;
            2:       v = 8'hAB;
            3:       v = 8'hCD;
            default: v = 8'(8'h10 + i);
        endcase
        if (copy && i >= 4) v = pattern[i-4];
        return v;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        rxd = b;
        @(posedge rxclk);
        #1;
    endtask

    task automatic send_header(input bit corrupt);
        send_byte(corrupt ? 8'hF7 : 8'hF6);
        send_byte(8'hF6);
        send_byte(8'hF6);
        send_byte(8'h28);
        send_byte(8'h28);
        send_byte(8'h28);
    endtask

    task automatic send_payload(input int from, input bit copy);
        for (int i = from; i < PAY; i++) send_byte(pay_byte(i, copy));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        #1 rst = 1'b0;
        cmp_en = 1'b1;
        #1;
        check("reset_rxd_out", 32'(rxd_out),     32'h00);
        check("reset_fb",      32'(frame_begin), 0);
        check("reset_in_sync", 32'(in_sync),     0);
        check("reset_lof",     32'(lof),         0);
        repeat (3) @(posedge rxclk);
        #1 rst = 1'b1;
        repeat (5) send_byte(8'h55);

        // First pattern: HUNT -> PRESYNC, no frame_begin yet.
        send_header(1'b0); send_byte(pay_byte(0, 1'b0));
        check("acq_first_fb", 32'(frame_begin), 0);
        check("acq_first_sync", 32'(in_sync), 0);
        send_payload(1, 1'b0);

        // Second pattern at the expected spacing: SYNC with frame_begin.
        send_header(1'b0); send_byte(pay_byte(0, 1'b0));
        check("acq_second_fb", 32'(frame_begin), 1);
        check("acq_second_rxd", 32'(rxd_out), 32'(PAY0_OUT));
        check("acq_second_sync", 32'(in_sync), 1);
        send_byte(pay_byte(1, 1'b0));
        check("acq_second_rxd1", 32'(rxd_out), 32'(PAY1_OUT));
        check("acq_second_fb_off", 32'(frame_begin), 0);
        send_payload(2, 1'b0);

        // Pattern copy inside the payload must be ignored.
        send_header(1'b0); send_byte(pay_byte(0, 1'b1)); send_payload(1, 1'b1);
        send_byte(8'hF6);
        check("copy_no_fb", 32'(frame_begin), 0);
        send_byte(8'hF6); send_byte(8'hF6); send_byte(8'h28); send_byte(8'h28); send_byte(8'h28);
        send_byte(pay_byte(0, 1'b0));
        check("after_copy_fb", 32'(frame_begin), 1);
        send_payload(1, 1'b0);

        // Single corruption: no frame_begin, stays in SYNC; next frame recovers.
        send_header(1'b1); send_byte(pay_byte(0, 1'b0));
        check("single_bad_fb", 32'(frame_begin), 0);
        check("single_bad_sync", 32'(in_sync), 1);
        send_payload(1, 1'b0);
        send_header(1'b0); send_byte(pay_byte(0, 1'b0));
        check("recover_fb", 32'(frame_begin), 1);
        send_payload(1, 1'b0);

        // Two consecutive corruptions: loss of frame.
        send_header(1'b1); send_byte(pay_byte(0, 1'b0));
        check("double_bad1_fb", 32'(frame_begin), 0);
        send_payload(1, 1'b0);
        send_header(1'b1); send_byte(pay_byte(0, 1'b0));
        check("double_bad2_fb", 32'(frame_begin), 0);
        check("lof_pulse", 32'(lof), 1);
        check("lof_in_sync", 32'(in_sync), 0);
        send_byte(pay_byte(1, 1'b0));
        check("lof_one_cycle", 32'(lof), 0);
        send_payload(2, 1'b0);

        // PRESYNC, then the second pattern is missing: back to HUNT.
        send_header(1'b0); send_payload(0, 1'b0);
        repeat (L) send_byte(8'h3C);
        check("presync_miss_sync", 32'(in_sync), 0);
        send_header(1'b0); send_byte(pay_byte(0, 1'b0));
        check("reacq1_fb", 32'(frame_begin), 0);
        send_payload(1, 1'b0);
        send_header(1'b0); send_byte(pay_byte(0, 1'b0));
        check("reacq2_fb", 32'(frame_begin), 1);
        send_payload(1, 1'b0);

        // Reset in the middle of an in-sync payload.
        send_header(1'b0); send_byte(pay_byte(0, 1'b0));
        send_byte(pay_byte(1, 1'b0)); send_byte(pay_byte(2, 1'b0));
        rst = 1'b0;
        #1;
        check("midrst_rxd_out", 32'(rxd_out),     32'h00);
        check("midrst_fb",      32'(frame_begin), 0);
        check("midrst_in_sync", 32'(in_sync),     0);
        check("midrst_lof",     32'(lof),         0);
        repeat (2) @(posedge rxclk);
        #1 rst = 1'b1;
        send_payload(3, 1'b0);
        send_header(1'b0); send_byte(pay_byte(0, 1'b0));
        check("post_rst1_fb", 32'(frame_begin), 0);
        send_payload(1, 1'b0);
        send_header(1'b0); send_byte(pay_byte(0, 1'b0));
        check("post_rst2_fb", 32'(frame_begin), 1);
        check("post_rst2_sync", 32'(in_sync), 1);
        send_payload(1, 1'b0);
        repeat (3) send_byte(8'h55);

        @(negedge rxclk);
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
